fc_controller: RTL and testbench

FC_CONTROLLER -- requirements
Module: fc_controller

---
 rtl/fc_controller_if.sv | 28 ++
 rtl/fc_controller.sv | 118 +++++++++++
 tb/tb_fc_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fc_controller_if.sv
// Control bundle between the FC layer sequencer and the SRAM/MAC datapath.
// The controller uses the master modport; the datapath side uses slave.
interface fc_controller_if #(
  parameter int WADDR_W = 15,
  parameter int IADDR_W = 6,
  parameter int OIDX_W  = 9
);
  logic               start;
  logic [WADDR_W-1:0] sram_raddr_weight;
  logic [IADDR_W-1:0] sram_raddr_input;
  logic               accumulate_reset;
  logic               out_valid;
  logic [OIDX_W-1:0]  out_index;
  logic               busy;
  logic               done;

  modport master (
    input  start,
    output sram_raddr_weight, sram_raddr_input, accumulate_reset,
           out_valid, out_index, busy, done
  );

  modport slave (
    output start,
    input  sram_raddr_weight, sram_raddr_input, accumulate_reset,
           out_valid, out_index, busy, done
  );
endinterface

// File: rtl/fc_controller.sv
// Sequencer for one fully-connected layer pass: issues weight/input SRAM reads
// and aligns MAC control (accumulate_reset, out_valid) to the read pipeline.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one (neuron j, chunk k) slot per cycle
// DRAIN | no issue; pipeline emptying until the last neuron is valid
// DONE  | one-cycle done pulse, then back to IDLE
module fc_controller #(
  parameter int IN_CHUNKS = 40,
  parameter int OUT_NUM   = 500,
  parameter int WADDR_W   = 15,
  parameter int IADDR_W   = 6,
  parameter int OIDX_W    = 9
) (
  input  logic            clk,
  input  logic            srstn,
  fc_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [IADDR_W-1:0] K_LAST = IADDR_W'(IN_CHUNKS - 1);
  localparam logic [OIDX_W-1:0]  J_LAST = OIDX_W'(OUT_NUM - 1);

  state_t             state;
  logic [IADDR_W-1:0] k_cnt;
  logic [OIDX_W-1:0]  j_cnt;
  logic [WADDR_W-1:0] waddr;
  logic [IADDR_W-1:0] iaddr;
  logic               busy_r;
  logic               done_r;

  // Tag pipeline: stage n is aligned with cycle c+n of the issuing slot.
  logic               s1_first, s2_first;
  logic               s1_last, s2_last, s3_last;
  logic [OIDX_W-1:0]  s1_idx, s2_idx, s3_idx;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state    <= IDLE;
      k_cnt    <= '0;
      j_cnt    <= '0;
      waddr    <= '0;
      iaddr    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      s1_first <= 1'b0;
      s2_first <= 1'b0;
      s1_last  <= 1'b0;
      s2_last  <= 1'b0;
      s3_last  <= 1'b0;
      s1_idx   <= '0;
      s2_idx   <= '0;
      s3_idx   <= '0;
    end else begin
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_idx   <= s1_idx;
      s3_last  <= s2_last;
      s3_idx   <= s2_idx;
      done_r   <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_r <= 1'b1;
            k_cnt  <= '0;
            j_cnt  <= '0;
            waddr  <= '0;
          end
        end
        RUN: begin
          s1_first <= (k_cnt == '0);
          s1_last  <= (k_cnt == K_LAST);
          s1_idx   <= j_cnt;
          iaddr    <= k_cnt;
          if (k_cnt == K_LAST) begin
            k_cnt <= '0;
            // Final slot: weight address stays on its last value.
            if (j_cnt == J_LAST) begin
              state <= DRAIN;
            end else begin
              j_cnt <= j_cnt + 1'b1;
              waddr <= waddr + 1'b1;
            end
          end else begin
            k_cnt <= k_cnt + 1'b1;
            waddr <= waddr + 1'b1;
          end
        end
        DRAIN: begin
          if (s3_last && (s3_idx == J_LAST)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sram_raddr_weight = waddr;
  assign bus.sram_raddr_input  = iaddr;
  assign bus.accumulate_reset  = s2_first;
  assign bus.out_valid         = s3_last;
  assign bus.out_index         = s3_idx;
  assign bus.busy              = busy_r;
  assign bus.done              = done_r;

endmodule

// File: tb/tb_fc_controller.sv
// Directed bench for fc_controller: small configurations with a MAC/SRAM model,
// single-chunk, held start, mid-pass reset and the default 40x500 pass.
module tb_fc_controller;

  logic clk;
  logic srstn;
  int   errors;
  int   checks;

  fc_controller_if b23 ();
  fc_controller_if b14 ();
  fc_controller_if bd  ();

  fc_controller #(.IN_CHUNKS(2),  .OUT_NUM(3))   u23 (.clk(clk), .srstn(srstn), .bus(b23));
  fc_controller #(.IN_CHUNKS(1),  .OUT_NUM(4))   u14 (.clk(clk), .srstn(srstn), .bus(b14));
  fc_controller #(.IN_CHUNKS(40), .OUT_NUM(500)) ud  (.clk(clk), .srstn(srstn), .bus(bd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM (1-cycle read) + MAC (weight registered once more, input combinational)
  int wmem [0:7];
  int imem [0:1];
  int w_q, w_mac, i_q, acc;
  int exp_dot [0:2];

  initial begin
    wmem = '{3, 1, 4, 1, 5, 9, 0, 0};
    imem = '{2, 7};
    exp_dot = '{13, 15, 73};
    w_q = 0; w_mac = 0; i_q = 0; acc = 0;
  end

  always @(posedge clk) begin
    w_q   <= wmem[b23.sram_raddr_weight[2:0]];
    w_mac <= w_q;
    i_q   <= imem[b23.sram_raddr_input[0]];
    if (b23.accumulate_reset) acc <= w_mac * i_q;
    else                      acc <= acc + w_mac * i_q;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (b23.busy !== 1'b0 || b23.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", b23.busy, b23.done); end
    checks++; if (int'(b23.sram_raddr_weight) !== 0) begin errors++; $display("FAIL reset_waddr got=%0d exp=0", b23.sram_raddr_weight); end
    checks++; if (int'(b23.sram_raddr_input) !== 0) begin errors++; $display("FAIL reset_iaddr got=%0d exp=0", b23.sram_raddr_input); end
    checks++; if (b23.accumulate_reset !== 1'b0 || b23.out_valid !== 1'b0) begin errors++; $display("FAIL reset_accrst_valid got=%b%b exp=00", b23.accumulate_reset, b23.out_valid); end
    checks++; if (int'(b23.out_index) !== 0) begin errors++; $display("FAIL reset_index got=%0d exp=0", b23.out_index); end
    checks++; if (b14.busy !== 1'b0 || bd.busy !== 1'b0 || bd.done !== 1'b0) begin errors++; $display("FAIL reset_others got=%b%b%b exp=000", b14.busy, bd.busy, bd.done); end
  endtask

  task automatic test_basic();
    b23.start = 1'b1;
    tick();
    b23.start = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      int ew, ei;
      logic ea, ev, ed, eb;
      ew = (t <= 6) ? t - 1 : 5;
      ei = (t >= 2 && t <= 7) ? (t - 2) % 2 : ((t > 7) ? 1 : 0);
      ea = (t == 3 || t == 5 || t == 7);
      ev = (t == 5 || t == 7 || t == 9);
      ed = (t == 10);
      eb = (t >= 1 && t <= 10);
      checks++; if (int'(b23.sram_raddr_weight) !== ew) begin errors++; $display("FAIL basic_waddr t=%0d got=%0d exp=%0d", t, b23.sram_raddr_weight, ew); end
      checks++; if (int'(b23.sram_raddr_input) !== ei) begin errors++; $display("FAIL basic_iaddr t=%0d got=%0d exp=%0d", t, b23.sram_raddr_input, ei); end
      checks++; if (b23.accumulate_reset !== ea) begin errors++; $display("FAIL basic_accrst t=%0d got=%b exp=%b", t, b23.accumulate_reset, ea); end
      checks++; if (b23.out_valid !== ev) begin errors++; $display("FAIL basic_valid t=%0d got=%b exp=%b", t, b23.out_valid, ev); end
      checks++; if (b23.done !== ed) begin errors++; $display("FAIL basic_done t=%0d got=%b exp=%b", t, b23.done, ed); end
      checks++; if (b23.busy !== eb) begin errors++; $display("FAIL basic_busy t=%0d got=%b exp=%b", t, b23.busy, eb); end
      if (ev) begin
        checks++; if (int'(b23.out_index) !== (t - 5) / 2) begin errors++; $display("FAIL basic_index t=%0d got=%0d exp=%0d", t, b23.out_index, (t - 5) / 2); end
        checks++; if (acc !== exp_dot[(t - 5) / 2]) begin errors++; $display("FAIL basic_dot t=%0d got=%0d exp=%0d", t, acc, exp_dot[(t - 5) / 2]); end
      end
      tick();
    end
  endtask

  task automatic test_single_chunk();
    b14.start = 1'b1;
    tick();
    b14.start = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      int ew;
      logic ea, ev, ed, eb;
      ew = (t <= 4) ? t - 1 : 3;
      ea = (t >= 3 && t <= 6);
      ev = (t >= 4 && t <= 7);
      ed = (t == 8);
      eb = (t <= 8);
      checks++; if (int'(b14.sram_raddr_weight) !== ew) begin errors++; $display("FAIL single_waddr t=%0d got=%0d exp=%0d", t, b14.sram_raddr_weight, ew); end
      checks++; if (b14.accumulate_reset !== ea) begin errors++; $display("FAIL single_accrst t=%0d got=%b exp=%b", t, b14.accumulate_reset, ea); end
      checks++; if (b14.out_valid !== ev) begin errors++; $display("FAIL single_valid t=%0d got=%b exp=%b", t, b14.out_valid, ev); end
      checks++; if (b14.done !== ed || b14.busy !== eb) begin errors++; $display("FAIL single_done_busy t=%0d got=%b%b exp=%b%b", t, b14.done, b14.busy, ed, eb); end
      if (ev) begin
        checks++; if (int'(b14.out_index) !== t - 4) begin errors++; $display("FAIL single_index t=%0d got=%0d exp=%0d", t, b14.out_index, t - 4); end
      end
      tick();
    end
  endtask

  task automatic test_hold_start();
    bit idle_seen;
    b23.start = 1'b1;
    tick();
    for (int t = 1; t <= 12; t++) begin
      logic ev, ed, eb;
      ev = (t == 5 || t == 7 || t == 9);
      ed = (t == 10);
      eb = (t != 11);
      checks++; if (b23.busy !== eb) begin errors++; $display("FAIL hold_busy t=%0d got=%b exp=%b", t, b23.busy, eb); end
      checks++; if (b23.out_valid !== ev || b23.done !== ed) begin errors++; $display("FAIL hold_valid_done t=%0d got=%b%b exp=%b%b", t, b23.out_valid, b23.done, ev, ed); end
      if (t == 11) begin
        checks++; if (int'(b23.sram_raddr_weight) !== 5) begin errors++; $display("FAIL hold_waddr_held got=%0d exp=5", b23.sram_raddr_weight); end
      end
      if (t == 12) begin
        checks++; if (int'(b23.sram_raddr_weight) !== 0) begin errors++; $display("FAIL hold_restart_waddr got=%0d exp=0", b23.sram_raddr_weight); end
      end
      tick();
    end
    b23.start = 1'b0;
    idle_seen = 1'b0;
    for (int n = 0; n < 30 && !idle_seen; n++) begin
      if (b23.busy === 1'b0) idle_seen = 1'b1;
      else tick();
    end
    checks++; if (!idle_seen) begin errors++; $display("FAIL hold_return_idle got=busy exp=idle"); end
  endtask

  task automatic test_reset_mid();
    b23.start = 1'b1;
    tick();
    b23.start = 1'b0;
    tick(); tick(); tick();
    checks++; if (int'(b23.sram_raddr_weight) !== 3 || b23.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%0d/%b exp=3/1", b23.sram_raddr_weight, b23.busy); end
    #3 srstn = 1'b0;
    #1;
    checks++; if (int'(b23.sram_raddr_weight) !== 0 || int'(b23.sram_raddr_input) !== 0) begin errors++; $display("FAIL midrst_addr got=%0d/%0d exp=0/0", b23.sram_raddr_weight, b23.sram_raddr_input); end
    checks++; if (b23.busy !== 1'b0 || b23.done !== 1'b0 || b23.out_valid !== 1'b0 || b23.accumulate_reset !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got=%b%b%b%b exp=0000", b23.busy, b23.done, b23.out_valid, b23.accumulate_reset); end
    @(posedge clk);
    #1 srstn = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      checks++; if (b23.out_valid !== 1'b0 || b23.done !== 1'b0 || b23.busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet t=%0d got=%b%b%b exp=000", t, b23.out_valid, b23.done, b23.busy); end
    end
  endtask

  task automatic test_defaults();
    int pulses;
    int done_t;
    pulses = 0;
    done_t = 0;
    bd.start = 1'b1;
    tick();
    bd.start = 1'b0;
    for (int t = 1; t <= 20010; t++) begin
      if (bd.out_valid === 1'b1) begin
        checks++; if (int'(bd.out_index) !== pulses) begin errors++; $display("FAIL dflt_index t=%0d got=%0d exp=%0d", t, bd.out_index, pulses); end
        pulses++;
      end
      if (bd.done === 1'b1 && done_t == 0) done_t = t;
      if (t == 20003) begin
        checks++; if (int'(bd.sram_raddr_weight) !== 19999) begin errors++; $display("FAIL dflt_final_waddr got=%0d exp=19999", bd.sram_raddr_weight); end
      end
      tick();
    end
    checks++; if (pulses !== 500) begin errors++; $display("FAIL dflt_pulses got=%0d exp=500", pulses); end
    checks++; if (done_t !== 20004) begin errors++; $display("FAIL dflt_done_cycle got=%0d exp=20004", done_t); end
    checks++; if (bd.busy !== 1'b0) begin errors++; $display("FAIL dflt_idle got=%b exp=0", bd.busy); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    srstn = 1'b0;
    b23.start = 1'b0;
    b14.start = 1'b0;
    bd.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    srstn = 1'b1;
    tick();
    test_basic();
    test_single_chunk();
    test_hold_start();
    test_reset_mid();
    test_defaults();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
